// File: rtl/onehot_sel_pkg.sv
// rtl/onehot_sel_pkg.sv - shared state and mode encodings for the one-hot channel sequencer
package onehot_sel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    GAP  = 2'b10
  } state_t;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  function automatic logic is_scan(input logic [1:0] m);
    return (m == MODE_UP) || (m == MODE_DOWN);
  endfunction

endpackage

// File: rtl/binary_to_onehot.sv
// rtl/binary_to_onehot.sv - combinational binary index to one-hot decoder
module binary_to_onehot #(
  parameter int SEL_WIDTH = 4,
  parameter int SEL_COUNT = 2 ** SEL_WIDTH
) (
  input  logic [SEL_WIDTH-1:0] bin,
  output logic [SEL_COUNT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < SEL_COUNT; i++) begin
      if (bin == SEL_WIDTH'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/onehot_sel_sequencer.sv
// rtl/onehot_sel_sequencer.sv - registered one-hot cell enable sequencer
// Break-before-make channel switching with manual loads and up/down auto-scan.
module onehot_sel_sequencer
  import onehot_sel_pkg::*;
#(
  parameter int SEL_WIDTH   = 4,
  parameter int SEL_COUNT   = 2 ** SEL_WIDTH,
  parameter int GAP_CYCLES  = 1,
  parameter int DWELL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [1:0]             mode,
  input  logic [SEL_WIDTH-1:0]   sel,
  input  logic                   load,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [SEL_COUNT-1:0]   oh,
  output logic [SEL_WIDTH-1:0]   cur,
  output logic                   busy,
  output logic                   wrap,
  output logic                   err
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0]        GAP_LOAD  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [SEL_WIDTH-1:0] LAST_IDX  = SEL_WIDTH'(SEL_COUNT - 1);
  localparam logic [31:0]          SEL_LIMIT = 32'(SEL_COUNT);

  state_t                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   cur_d;
  logic [SEL_WIDTH-1:0]   target_q, target_d;
  logic                   twrap_q, twrap_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic                   wrap_d, err_d;

  logic                   load_ok;
  logic                   scan;
  logic [DWELL_WIDTH-1:0] dwell_load;
  logic [SEL_WIDTH-1:0]   scan_next;
  logic                   scan_wrap;
  logic [SEL_COUNT-1:0]   dec;

  assign load_ok    = load && (32'(sel) < SEL_LIMIT);
  assign scan       = is_scan(mode);
  // dwell counts down to zero; zero requested dwell behaves as one cycle
  assign dwell_load = (dwell == '0) ? '0 : dwell - 1'b1;

  always_comb begin
    if (mode == MODE_UP) begin
      scan_wrap = (cur == LAST_IDX);
      scan_next = scan_wrap ? '0 : cur + 1'b1;
    end else begin
      scan_wrap = (cur == '0);
      scan_next = scan_wrap ? LAST_IDX : cur - 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur;
    target_d = target_q;
    twrap_d  = twrap_q;
    gap_d    = gap_q;
    dwell_d  = dwell_q;
    wrap_d   = 1'b0;
    err_d    = load && !load_ok;

    if (!ena || mode == MODE_OFF) begin
      state_d = IDLE;
      twrap_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_ok) begin
            state_d = ON;
            cur_d   = sel;
            dwell_d = dwell_load;
          end else if (scan) begin
            state_d = ON;
            dwell_d = dwell_load;
          end
        end

        ON: begin
          if (dwell_q != '0) dwell_d = dwell_q - 1'b1;
          if (load_ok && sel == cur) begin
            dwell_d = dwell_load;
          end else if (load_ok || (scan && dwell_q == '0)) begin
            // a load outranks a simultaneous dwell expiry and never flags wrap
            target_d = load_ok ? sel : scan_next;
            if (GAP_CYCLES == 0) begin
              cur_d   = target_d;
              wrap_d  = !load_ok && scan_wrap;
              dwell_d = dwell_load;
            end else begin
              state_d = GAP;
              twrap_d = !load_ok && scan_wrap;
              gap_d   = GAP_LOAD;
            end
          end
        end

        GAP: begin
          if (load_ok) begin
            target_d = sel;
            twrap_d  = 1'b0;
          end
          if (gap_q == '0) begin
            state_d = ON;
            cur_d   = target_d;
            wrap_d  = twrap_d;
            dwell_d = dwell_load;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  binary_to_onehot #(
    .SEL_WIDTH (SEL_WIDTH),
    .SEL_COUNT (SEL_COUNT)
  ) u_dec (
    .bin    (cur_d),
    .onehot (dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cur      <= '0;
      target_q <= '0;
      twrap_q  <= 1'b0;
      gap_q    <= '0;
      dwell_q  <= '0;
      oh       <= '0;
      busy     <= 1'b0;
      wrap     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur      <= cur_d;
      target_q <= target_d;
      twrap_q  <= twrap_d;
      gap_q    <= gap_d;
      dwell_q  <= dwell_d;
      oh       <= (state_d == ON) ? dec : '0;
      busy     <= (state_d == GAP);
      wrap     <= wrap_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_onehot_sel_sequencer.sv
// tb/tb_onehot_sel_sequencer.sv - directed and randomized bench for onehot_sel_sequencer
module tb_onehot_sel_sequencer;

  localparam int W  = 4;
  localparam int N  = 10;
  localparam int G  = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  sel = '0;
  logic          load = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic [N-1:0]  oh;
  logic [W-1:0]  cur;
  logic          busy, wrap, err;

  int checks = 0;
  int passed = 0;

  // reference model state (spec-level: elapsed on-time vs dwell, remaining gap)
  bit m_on, m_gap, m_tgt_wrap, m_wrap, m_err;
  int m_cur, m_tgt, m_gap_left, m_on_cnt, m_d;

  onehot_sel_sequencer #(
    .SEL_WIDTH   (W),
    .SEL_COUNT   (N),
    .GAP_CYCLES  (G),
    .DWELL_WIDTH (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .mode  (mode),
    .sel   (sel),
    .load  (load),
    .dwell (dwell),
    .oh    (oh),
    .cur   (cur),
    .busy  (busy),
    .wrap  (wrap),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic enter_on(input int idx, input bit w);
    m_on = 1; m_gap = 0; m_cur = idx; m_on_cnt = 0;
    m_d = (dwell == 0) ? 1 : int'(dwell);
    m_wrap = w;
  endtask

  task automatic start_change(input int idx, input bit w);
    if (G == 0) enter_on(idx, w);
    else begin
      m_on = 0; m_gap = 1; m_gap_left = G; m_tgt = idx; m_tgt_wrap = w;
    end
  endtask

  task automatic model_step();
    bit valid, scanning, up;
    m_wrap = 0; m_err = 0;
    if (!rst_n) begin
      m_on = 0; m_gap = 0; m_cur = 0; m_tgt = 0; m_tgt_wrap = 0;
      m_gap_left = 0; m_on_cnt = 0; m_d = 1;
    end else begin
      valid    = load && (int'(sel) < N);
      m_err    = load && (int'(sel) >= N);
      scanning = (mode == 2'd1) || (mode == 2'd2);
      up       = (mode == 2'd1);
      if (!ena || mode == 2'd3) begin
        m_on = 0; m_gap = 0;
      end else if (m_gap) begin
        if (valid) begin m_tgt = int'(sel); m_tgt_wrap = 0; end
        m_gap_left--;
        if (m_gap_left == 0) enter_on(m_tgt, m_tgt_wrap);
      end else if (m_on) begin
        m_on_cnt++;
        if (valid && int'(sel) == m_cur) begin
          m_on_cnt = 0;
          m_d = (dwell == 0) ? 1 : int'(dwell);
        end else if (valid) begin
          start_change(int'(sel), 0);
        end else if (scanning && m_on_cnt >= m_d) begin
          if (up) start_change((m_cur + 1) % N, m_cur == N - 1);
          else    start_change((m_cur + N - 1) % N, m_cur == 0);
        end
      end else if (valid) begin
        enter_on(int'(sel), 0);
      end else if (scanning) begin
        enter_on(m_cur, 0);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; ena = 0; mode = 2'd0; load = 0;
    tick(); tick();
    checks++; if (oh !== '0) $display("FAIL reset_oh: got %h want 0", oh); else passed++;
    checks++; if (cur !== '0) $display("FAIL reset_cur: got %0d want 0", cur); else passed++;
    checks++; if (busy !== 1'b0 || wrap !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_flags: got busy=%b wrap=%b err=%b want 000", busy, wrap, err); else passed++;
    rst_n = 1; ena = 1; sel = 4'd5; load = 1;
    tick();
    load = 0;
    checks++; if (oh !== 10'h020) $display("FAIL idle_load_oh: got %h want 020", oh); else passed++;
    checks++; if (cur !== 4'd5 || busy !== 1'b0)
      $display("FAIL idle_load_cur: got cur=%0d busy=%b want 5/0", cur, busy); else passed++;
  endtask

  task automatic test_break_before_make();
    sel = 4'd9; load = 1;
    tick();
    load = 0;
    for (int i = 0; i < G; i++) begin
      checks++; if (oh !== '0 || busy !== 1'b1)
        $display("FAIL bbm_gap%0d: got oh=%h busy=%b want 0/1", i, oh, busy); else passed++;
      if (i < G - 1) tick();
    end
    tick();
    checks++; if (oh !== 10'h200 || cur !== 4'd9 || busy !== 1'b0)
      $display("FAIL bbm_on: got oh=%h cur=%0d busy=%b want 200/9/0", oh, cur, busy); else passed++;
    sel = 4'd3; load = 1;
    tick();
    checks++; if (busy !== 1'b1 || cur !== 4'd9)
      $display("FAIL bbm_retarget_gap: got busy=%b cur=%0d want 1/9", busy, cur); else passed++;
    sel = 4'd6;
    tick();
    load = 0;
    checks++; if (oh !== '0 || busy !== 1'b1)
      $display("FAIL bbm_retarget_gap2: got oh=%h busy=%b want 0/1", oh, busy); else passed++;
    tick();
    checks++; if (oh !== 10'h040 || cur !== 4'd6 || busy !== 1'b0)
      $display("FAIL bbm_last_wins: got oh=%h cur=%0d busy=%b want 040/6/0", oh, cur, busy); else passed++;
  endtask

  task automatic test_scan_up();
    logic [N-1:0] exp_tab [11];
    logic [N-1:0] ohv;
    bit seen;
    exp_tab = '{10'h100, 10'h100, 10'h100, 10'h000, 10'h000,
                10'h200, 10'h200, 10'h200, 10'h000, 10'h000, 10'h001};
    mode = 2'd3; tick();
    mode = 2'd1; dwell = 8'd3; sel = 4'd8; load = 1;
    tick();
    load = 0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      ohv = exp_tab[i];
      checks++; if (oh !== ohv || busy !== (ohv == '0) || wrap !== (i == 10))
        $display("FAIL scan_up_step%0d: got oh=%h busy=%b wrap=%b want %h/%b/%b",
                 i, oh, busy, wrap, ohv, ohv == '0, i == 10); else passed++;
    end
    dwell = 8'd0;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (oh === 10'h002) seen = 1;
    end
    checks++; if (!seen) $display("FAIL scan_up_dwell0_timeout: got oh=%h want 002", oh); else passed++;
    tick();
    checks++; if (oh !== '0 || busy !== 1'b1)
      $display("FAIL scan_up_dwell0_len: got oh=%h busy=%b want 0/1", oh, busy); else passed++;
  endtask

  task automatic test_scan_down();
    mode = 2'd3; tick();
    mode = 2'd2; dwell = 8'd4; sel = 4'd0; load = 1;
    tick();
    load = 0;
    tick(); tick(); tick();
    sel = 4'd2; load = 1;
    tick();
    load = 0;
    checks++; if (oh !== '0 || busy !== 1'b1)
      $display("FAIL down_race_gap: got oh=%h busy=%b want 0/1", oh, busy); else passed++;
    tick(); tick();
    checks++; if (oh !== 10'h004 || cur !== 4'd2 || wrap !== 1'b0)
      $display("FAIL down_race_load_wins: got oh=%h cur=%0d wrap=%b want 004/2/0", oh, cur, wrap); else passed++;
    mode = 2'd3; tick();
    mode = 2'd2; sel = 4'd0; load = 1;
    tick();
    load = 0;
    tick(); tick(); tick(); tick(); tick(); tick();
    checks++; if (oh !== 10'h200 || cur !== 4'd9 || wrap !== 1'b1)
      $display("FAIL down_wrap: got oh=%h cur=%0d wrap=%b want 200/9/1", oh, cur, wrap); else passed++;
    tick();
    checks++; if (wrap !== 1'b0 || oh !== 10'h200)
      $display("FAIL down_wrap_pulse: got wrap=%b oh=%h want 0/200", wrap, oh); else passed++;
  endtask

  task automatic test_reject_off();
    mode = 2'd0; sel = 4'd12; load = 1;
    tick();
    load = 0;
    checks++; if (err !== 1'b1 || oh !== 10'h200 || cur !== 4'd9 || busy !== 1'b0)
      $display("FAIL reject_err: got err=%b oh=%h cur=%0d busy=%b want 1/200/9/0", err, oh, cur, busy); else passed++;
    tick();
    checks++; if (err !== 1'b0 || oh !== 10'h200)
      $display("FAIL reject_pulse: got err=%b oh=%h want 0/200", err, oh); else passed++;
    sel = 4'd4; load = 1;
    tick();
    load = 0;
    checks++; if (busy !== 1'b1) $display("FAIL off_pre_gap: got busy=%b want 1", busy); else passed++;
    mode = 2'd3;
    tick();
    checks++; if (oh !== '0 || busy !== 1'b0 || cur !== 4'd9)
      $display("FAIL off_mid_gap: got oh=%h busy=%b cur=%0d want 0/0/9", oh, busy, cur); else passed++;
    mode = 2'd0;
    tick(); tick(); tick();
    checks++; if (oh !== '0 || cur !== 4'd9)
      $display("FAIL off_target_dropped: got oh=%h cur=%0d want 0/9", oh, cur); else passed++;
  endtask

  task automatic test_reset_mid();
    mode = 2'd1; dwell = 8'd5; sel = 4'd7; load = 1;
    tick();
    load = 0;
    checks++; if (oh !== 10'h080) $display("FAIL rstmid_on: got oh=%h want 080", oh); else passed++;
    tick(); tick();
    rst_n = 0;
    tick();
    checks++; if (oh !== '0 || cur !== '0 || busy !== 1'b0 || wrap !== 1'b0 || err !== 1'b0)
      $display("FAIL rstmid_state: got oh=%h cur=%0d busy=%b wrap=%b err=%b want all 0",
               oh, cur, busy, wrap, err); else passed++;
    rst_n = 1; mode = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (oh !== '0 || wrap !== 1'b0 || err !== 1'b0)
        $display("FAIL rstmid_after%0d: got oh=%h wrap=%b err=%b want 0/0/0", i, oh, wrap, err); else passed++;
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_oh;
    for (int i = 0; i < 3000; i++) begin
      if (i % 25 == 0) mode = 2'($urandom_range(0, 3));
      ena   = ($urandom_range(0, 49) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      load  = ($urandom_range(0, 4) == 0);
      sel   = 4'($urandom_range(0, 15));
      dwell = 8'($urandom_range(0, 4));
      tick();
      exp_oh = m_on ? (N'(1) << m_cur) : '0;
      checks++; if (oh !== exp_oh) $display("FAIL rand_oh@%0d: got %h want %h", i, oh, exp_oh); else passed++;
      checks++; if (cur !== W'(m_cur)) $display("FAIL rand_cur@%0d: got %0d want %0d", i, cur, m_cur); else passed++;
      checks++; if (busy !== m_gap) $display("FAIL rand_busy@%0d: got %b want %b", i, busy, m_gap); else passed++;
      checks++; if (wrap !== m_wrap) $display("FAIL rand_wrap@%0d: got %b want %b", i, wrap, m_wrap); else passed++;
      checks++; if (err !== m_err) $display("FAIL rand_err@%0d: got %b want %b", i, err, m_err); else passed++;
    end
    load = 0;
  endtask

  initial begin
    test_reset();
    test_break_before_make();
    test_scan_up();
    test_scan_down();
    test_reject_off();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
